ddram_burst_reader: RTL

- Avalon-MM burst-read master for one 64-bit f2h_sdram port of the HPS memory bridge (ram1/ram2 style: 29-bit word address, 8-bit burstcount).
- Accepts a (start address, word count) job and splits it into bursts of at most BURST_MAX words.
- Issues a burst only when the local output FIFO can absorb every outstanding word.
- Delivers data in order on a valid/ready stream for core-side consumers (tape/ROM loaders, frame fetch).

---
 rtl/ddram_burst_reader_if.sv | 43 ++++
 rtl/ddram_burst_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ddram_burst_reader_if.sv
// Bundles the job request, Avalon-MM read master and output stream of ddram_burst_reader.
// Valid/ready rule: a job transfers on the edge where req_valid && req_ready; a stream word on dout_valid && dout_ready.
interface ddram_burst_reader_if #(
    parameter int ADDR_W = 29,
    parameter int LEN_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        ram_burstcount;
    logic              ram_read;
    logic              ram_write;
    logic [7:0]        ram_byteenable;
    logic [63:0]       ram_writedata;
    logic              ram_waitrequest;
    logic [63:0]       ram_readdata;
    logic              ram_readdatavalid;
    logic              dout_valid;
    logic [63:0]       dout_data;
    logic              dout_ready;
    logic [1:0]        dbg_state;

    modport master (
        input  req_valid, req_addr, req_len, abort,
        input  ram_waitrequest, ram_readdata, ram_readdatavalid, dout_ready,
        output req_ready, busy, done,
        output ram_address, ram_burstcount, ram_read, ram_write, ram_byteenable, ram_writedata,
        output dout_valid, dout_data, dbg_state
    );

    modport slave (
        output req_valid, req_addr, req_len, abort,
        output ram_waitrequest, ram_readdata, ram_readdatavalid, dout_ready,
        input  req_ready, busy, done,
        input  ram_address, ram_burstcount, ram_read, ram_write, ram_byteenable, ram_writedata,
        input  dout_valid, dout_data, dbg_state
    );
endinterface

// File: rtl/ddram_burst_reader.sv
// Avalon-MM burst-read master: splits a (address, length) job into bursts and streams the
// returned 64-bit words in order through a first-word-fall-through FIFO.
module ddram_burst_reader #(
    parameter int ADDR_W     = 29,
    parameter int LEN_W      = 16,
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    ddram_burst_reader_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = CW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DATA, S_DRAIN} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_next, w_addr_eff;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
    logic [LEN_W-1:0]  r_remaining, w_remaining_next, w_rem_eff, w_blen;
    logic [7:0]        r_ram_bc, w_ram_bc_next;
    logic              r_ram_read, w_ram_read_next;
    logic              r_done, w_done_next;
    logic [CW-1:0]     r_outst, w_outst_next;
    logic [CW-1:0]     r_count, w_count_next;
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [63:0]       r_mem [FIFO_DEPTH];
    logic [KW-1:0]     w_credit;
    logic              w_stall, w_bus_accept, w_rdv_ok, w_push, w_pop, w_dout_valid;

    assign w_stall      = r_ram_read && bus.ram_waitrequest;
    assign w_bus_accept = r_ram_read && !bus.ram_waitrequest;
    // Stray readdatavalid with nothing outstanding is ignored entirely.
    assign w_rdv_ok     = bus.ram_readdatavalid && (r_outst != '0);
    assign w_push       = w_rdv_ok && (r_state != S_DRAIN);
    assign w_dout_valid = (r_count != '0) && (r_state != S_DRAIN);
    assign w_pop        = w_dout_valid && bus.dout_ready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_outst_next = r_outst + (w_bus_accept ? CW'(r_ram_bc) : '0) - CW'(w_rdv_ok);

    // Values as they will stand after this edge, so a new burst can follow an accepted one directly.
    assign w_rem_eff  = w_bus_accept ? r_remaining - LEN_W'(r_ram_bc) : r_remaining;
    assign w_addr_eff = w_bus_accept ? r_cur_addr + ADDR_W'(r_ram_bc) : r_cur_addr;
    assign w_blen     = (w_rem_eff > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : w_rem_eff;
    assign w_credit   = KW'(FIFO_DEPTH) - KW'(w_count_next) - KW'(w_outst_next);

    always_comb begin
        w_state_next     = r_state;
        w_ram_read_next  = r_ram_read;
        w_ram_addr_next  = r_ram_addr;
        w_ram_bc_next    = r_ram_bc;
        w_done_next      = 1'b0;
        w_cur_addr_next  = w_addr_eff;
        w_remaining_next = w_rem_eff;
        case (r_state)
            S_IDLE: begin
                w_ram_read_next = 1'b0;
                if (bus.req_valid) begin
                    w_cur_addr_next  = bus.req_addr;
                    w_remaining_next = bus.req_len;
                    if (bus.req_len == '0) w_done_next = 1'b1;
                    else                   w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!w_stall) begin
                    if (bus.abort) begin
                        w_ram_read_next = 1'b0;
                        w_state_next    = S_DRAIN;
                    end else if (w_rem_eff == '0) begin
                        w_ram_read_next = 1'b0;
                        w_state_next    = S_WAIT_DATA;
                    end else if (w_credit >= KW'(w_blen)) begin
                        w_ram_read_next = 1'b1;
                        w_ram_addr_next = w_addr_eff;
                        w_ram_bc_next   = w_blen[7:0];
                    end else begin
                        w_ram_read_next = 1'b0;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (bus.abort) begin
                    w_state_next = S_DRAIN;
                end else if (w_outst_next == '0) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_ram_read_next = 1'b0;
                if (r_outst == '0) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_outst     <= '0;
            r_ram_read  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_bc    <= '0;
            r_done      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_cur_addr  <= w_cur_addr_next;
            r_remaining <= w_remaining_next;
            r_outst     <= w_outst_next;
            r_ram_read  <= w_ram_read_next;
            r_ram_addr  <= w_ram_addr_next;
            r_ram_bc    <= w_ram_bc_next;
            r_done      <= w_done_next;
            if (r_state == S_DRAIN) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.ram_readdata;
    end

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = r_done;
    assign bus.ram_address    = r_ram_addr;
    assign bus.ram_burstcount = r_ram_bc;
    assign bus.ram_read       = r_ram_read;
    assign bus.ram_write      = 1'b0;
    assign bus.ram_byteenable = 8'hFF;
    assign bus.ram_writedata  = '0;
    assign bus.dout_valid     = w_dout_valid;
    assign bus.dout_data      = r_mem[r_rd_ptr];
    assign bus.dbg_state      = r_state;
endmodule
